// File: rtl/core_ctrl_pkg.sv
// Shared control types for the core pipeline: hold levels, sequencer states and pending tags.
// hold_e is ordered so that a larger value always means a deeper stall.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        HOLD_NONE = 3'd0,
        HOLD_PC   = 3'd1,
        HOLD_IF   = 3'd2,
        HOLD_ID   = 3'd3
    } hold_e;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        FLUSH  = 3'd1,
        DRAIN  = 3'd2,
        DRAIN2 = 3'd3,
        TRAP   = 3'd4,
        HALT   = 3'd5
    } ctrl_state_e;

    typedef enum logic {
        TAG_INT  = 1'b0,
        TAG_HALT = 1'b1
    } pend_tag_e;

    localparam int unsigned CNT_W = 3;

    function automatic hold_e hold_max(input hold_e a, input hold_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/redirect/interrupt signal bundle between pipe_ctrl and the rest of the core.
// master drives requests and consumes hold/jump; slave is the sequencer itself.
interface pipe_ctrl_if
    import core_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic              jump_req_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              ex_busy_i;
    logic              rib_hold_req_i;
    logic              halt_req_i;
    logic              int_req_i;
    logic [ADDR_W-1:0] int_addr_i;
    logic [ADDR_W-1:0] ex_inst_addr_i;
    hold_e             hold_flag_o;
    logic              jump_flag_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic              int_ack_o;
    logic [ADDR_W-1:0] int_epc_o;
    logic              halted_o;

    modport master (
        output jump_req_i, jump_addr_i, ex_busy_i, rib_hold_req_i, halt_req_i,
        output int_req_i, int_addr_i, ex_inst_addr_i,
        input  hold_flag_o, jump_flag_o, jump_addr_o, int_ack_o, int_epc_o, halted_o
    );

    modport slave (
        input  jump_req_i, jump_addr_i, ex_busy_i, rib_hold_req_i, halt_req_i,
        input  int_req_i, int_addr_i, ex_inst_addr_i,
        output hold_flag_o, jump_flag_o, jump_addr_o, int_ack_o, int_epc_o, halted_o
    );

endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall sources into one hold level, issues jump/flush sequences
// and sequences interrupt entry / debug halt (drain EX, redirect PC, ack CLINT).
module pipe_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned FLUSH_CYC = 1
) (
    input logic        clk_i,
    input logic        rst_n_i,
    pipe_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYC - 1);

    ctrl_state_e       r_state, w_state_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    pend_tag_e         r_tag, w_tag_d;
    logic              r_pend, w_pend_d;
    logic [ADDR_W-1:0] r_epc, w_epc_d;
    logic              r_halted, w_halted_d;

    hold_e             w_hold_fsm;
    hold_e             w_hold_rib;
    logic              w_jump_flag;
    logic [ADDR_W-1:0] w_jump_addr;
    logic              w_int_ack;
    logic              w_req;

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_tag_d     = r_tag;
        w_pend_d    = r_pend;
        w_epc_d     = r_epc;
        w_halted_d  = r_halted;
        w_hold_fsm  = HOLD_NONE;
        w_jump_flag = 1'b0;
        w_jump_addr = '0;
        w_int_ack   = 1'b0;
        w_req       = (r_tag == TAG_HALT) ? bus.halt_req_i : bus.int_req_i;

        unique case (r_state)
            RUN: begin
                if (bus.jump_req_i) begin
                    w_jump_flag = 1'b1;
                    w_jump_addr = bus.jump_addr_i;
                    w_hold_fsm  = HOLD_ID;
                    w_cnt_d     = CNT_INIT;
                    w_pend_d    = 1'b0;
                    w_state_d   = FLUSH;
                end else if (bus.ex_busy_i) begin
                    w_hold_fsm = HOLD_ID;
                end else if (bus.halt_req_i) begin
                    w_hold_fsm = HOLD_IF;
                    w_tag_d    = TAG_HALT;
                    w_state_d  = DRAIN;
                end else if (bus.int_req_i) begin
                    w_hold_fsm = HOLD_IF;
                    w_tag_d    = TAG_INT;
                    w_state_d  = DRAIN;
                end
            end

            FLUSH: begin
                w_hold_fsm = HOLD_IF;
                if (r_cnt == '0) begin
                    w_state_d = r_pend ? DRAIN2 : RUN;
                    w_pend_d  = 1'b0;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end

            DRAIN, DRAIN2: begin
                w_hold_fsm = HOLD_IF;
                // A taken branch in EX must still redirect; its target becomes the return address.
                if (r_state == DRAIN && bus.jump_req_i) begin
                    w_jump_flag = 1'b1;
                    w_jump_addr = bus.jump_addr_i;
                    w_hold_fsm  = HOLD_ID;
                    w_cnt_d     = CNT_INIT;
                    w_epc_d     = bus.jump_addr_i;
                    w_pend_d    = w_req;
                    w_state_d   = FLUSH;
                end else if (!w_req) begin
                    w_state_d = RUN;
                end else if (!bus.ex_busy_i) begin
                    if (r_state == DRAIN) begin
                        w_epc_d = bus.ex_inst_addr_i;
                    end
                    if (r_tag == TAG_INT) begin
                        w_state_d = TRAP;
                    end else begin
                        w_halted_d = 1'b1;
                        w_state_d  = HALT;
                    end
                end
            end

            TRAP: begin
                w_jump_flag = 1'b1;
                w_jump_addr = bus.int_addr_i;
                w_int_ack   = 1'b1;
                w_hold_fsm  = HOLD_ID;
                w_cnt_d     = CNT_INIT;
                w_state_d   = FLUSH;
            end

            HALT: begin
                w_hold_fsm = HOLD_ID;
                if (!bus.halt_req_i) begin
                    w_halted_d = 1'b0;
                    w_cnt_d    = CNT_INIT;
                    w_state_d  = FLUSH;
                end
            end

            default: begin
                w_state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_tag    <= TAG_INT;
            r_pend   <= 1'b0;
            r_epc    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_tag    <= w_tag_d;
            r_pend   <= w_pend_d;
            r_epc    <= w_epc_d;
            r_halted <= w_halted_d;
        end
    end

    assign w_hold_rib = bus.rib_hold_req_i ? HOLD_PC : HOLD_NONE;

    // Combinational outputs are forced quiet while reset is held so nothing leaks mid-sequence.
    assign bus.hold_flag_o = rst_n_i ? hold_max(w_hold_fsm, w_hold_rib) : HOLD_NONE;
    assign bus.jump_flag_o = rst_n_i & w_jump_flag;
    assign bus.jump_addr_o = rst_n_i ? w_jump_addr : '0;
    assign bus.int_ack_o   = rst_n_i & w_int_ack;
    assign bus.int_epc_o   = r_epc;
    assign bus.halted_o    = r_halted;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: jump/flush, stall merge, interrupt entry, halt and reset abort.
module tb_pipe_ctrl;
    import core_ctrl_pkg::*;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk_i = ~clk_i;

    pipe_ctrl_if #(.ADDR_W(32)) bus ();

    pipe_ctrl #(
        .ADDR_W    (32),
        .FLUSH_CYC (1)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] hold, input logic jf,
                           input logic [31:0] ja, input logic ack);
        chk({tag, ".hold"}, 32'(bus.hold_flag_o), 32'(hold));
        chk({tag, ".jflag"}, 32'(bus.jump_flag_o), 32'(jf));
        chk({tag, ".jaddr"}, bus.jump_addr_o, ja);
        chk({tag, ".ack"}, 32'(bus.int_ack_o), 32'(ack));
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        bus.jump_req_i     = 1'b0;
        bus.jump_addr_i    = '0;
        bus.ex_busy_i      = 1'b0;
        bus.rib_hold_req_i = 1'b0;
        bus.halt_req_i     = 1'b0;
        bus.int_req_i      = 1'b0;
        bus.int_addr_i     = 32'h40;
        bus.ex_inst_addr_i = 32'h80;

        #12;
        chk_out("reset", 3'd0, 1'b0, 32'h0, 1'b0);
        chk("reset.epc", bus.int_epc_o, 32'h0);
        chk("reset.halted", 32'(bus.halted_o), 32'h0);
        rst_n_i = 1'b1;

        // T1: jump in RUN
        step();
        bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h100;
        #1 chk_out("t1.c0", 3'd3, 1'b1, 32'h100, 1'b0);
        step();
        bus.jump_req_i = 1'b0;
        #1 chk_out("t1.c1", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        #1 chk_out("t1.c2", 3'd0, 1'b0, 32'h0, 1'b0);

        // T2: ex_busy masks rib, then rib alone
        bus.ex_busy_i = 1'b1; bus.rib_hold_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2.busy.hold", 32'(bus.hold_flag_o), 32'd3);
            step();
        end
        bus.ex_busy_i = 1'b0;
        #1 chk("t2.rib0.hold", 32'(bus.hold_flag_o), 32'd1);
        step();
        #1 chk("t2.rib1.hold", 32'(bus.hold_flag_o), 32'd1);
        bus.rib_hold_req_i = 1'b0;
        #1 chk("t2.idle.hold", 32'(bus.hold_flag_o), 32'd0);

        // T3: interrupt with EX draining two cycles
        step();
        bus.int_req_i = 1'b1;
        #1 chk_out("t3.run", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        bus.ex_busy_i = 1'b1;
        #1 chk_out("t3.drain0", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        #1 chk_out("t3.drain1", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        bus.ex_busy_i = 1'b0;
        #1 chk_out("t3.drain2", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        #1 chk_out("t3.trap", 3'd3, 1'b1, 32'h40, 1'b1);
        chk("t3.epc", bus.int_epc_o, 32'h80);
        step();
        bus.int_req_i = 1'b0;
        #1 chk_out("t3.flush", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        #1 chk_out("t3.run2", 3'd0, 1'b0, 32'h0, 1'b0);

        // T4: jump arriving during DRAIN becomes the return address
        step();
        bus.int_req_i = 1'b1;
        #1 chk_out("t4.run", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        bus.ex_busy_i = 1'b1; bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h200;
        #1 chk_out("t4.jump", 3'd3, 1'b1, 32'h200, 1'b0);
        step();
        bus.ex_busy_i = 1'b0; bus.jump_req_i = 1'b0;
        #1 chk_out("t4.flush", 3'd2, 1'b0, 32'h0, 1'b0);
        chk("t4.epc_cap", bus.int_epc_o, 32'h200);
        step();
        bus.ex_inst_addr_i = 32'h300;
        #1 chk_out("t4.drain2", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        #1 chk_out("t4.trap", 3'd3, 1'b1, 32'h40, 1'b1);
        chk("t4.epc", bus.int_epc_o, 32'h200);
        step();
        bus.int_req_i = 1'b0;
        #1 chk_out("t4.flush2", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        #1 chk("t4.idle.hold", 32'(bus.hold_flag_o), 32'd0);

        // T5: halt and interrupt together; halt first, interrupt after resume
        step();
        bus.halt_req_i = 1'b1; bus.int_req_i = 1'b1; bus.ex_inst_addr_i = 32'h84;
        #1 chk_out("t5.run", 3'd2, 1'b0, 32'h0, 1'b0);
        chk("t5.run.halted", 32'(bus.halted_o), 32'h0);
        step();
        #1 chk_out("t5.drain", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        #1 chk_out("t5.halt", 3'd3, 1'b0, 32'h0, 1'b0);
        chk("t5.halted", 32'(bus.halted_o), 32'h1);
        chk("t5.epc", bus.int_epc_o, 32'h84);
        step();
        bus.halt_req_i = 1'b0;
        #1 chk_out("t5.release", 3'd3, 1'b0, 32'h0, 1'b0);
        step();
        bus.ex_inst_addr_i = 32'h88;
        #1 chk_out("t5.flush", 3'd2, 1'b0, 32'h0, 1'b0);
        chk("t5.flush.halted", 32'(bus.halted_o), 32'h0);
        step();
        #1 chk_out("t5.run_int", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        #1 chk_out("t5.drain_int", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        #1 chk_out("t5.trap", 3'd3, 1'b1, 32'h40, 1'b1);
        chk("t5.trap.epc", bus.int_epc_o, 32'h88);
        step();
        bus.int_req_i = 1'b0;
        #1 chk_out("t5.flush2", 3'd2, 1'b0, 32'h0, 1'b0);
        step();
        #1 chk("t5.idle.hold", 32'(bus.hold_flag_o), 32'd0);

        // T6a: reset while in DRAIN
        step();
        bus.int_req_i = 1'b1;
        #1 chk("t6a.run.hold", 32'(bus.hold_flag_o), 32'd2);
        step();
        bus.ex_busy_i = 1'b1;
        #1 chk("t6a.drain.hold", 32'(bus.hold_flag_o), 32'd2);
        rst_n_i = 1'b0;
        #1 chk_out("t6a.rst", 3'd0, 1'b0, 32'h0, 1'b0);
        chk("t6a.rst.epc", bus.int_epc_o, 32'h0);
        chk("t6a.rst.halted", 32'(bus.halted_o), 32'h0);
        bus.int_req_i = 1'b0; bus.ex_busy_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        step();
        #1 chk_out("t6a.after", 3'd0, 1'b0, 32'h0, 1'b0);

        // T6b: reset while in TRAP
        bus.int_req_i = 1'b1;
        #1 chk("t6b.run.hold", 32'(bus.hold_flag_o), 32'd2);
        step();
        #1 chk("t6b.drain.hold", 32'(bus.hold_flag_o), 32'd2);
        step();
        #1 chk_out("t6b.trap", 3'd3, 1'b1, 32'h40, 1'b1);
        rst_n_i = 1'b0;
        #1 chk_out("t6b.rst", 3'd0, 1'b0, 32'h0, 1'b0);
        chk("t6b.rst.epc", bus.int_epc_o, 32'h0);
        bus.int_req_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        step();
        #1 chk_out("t6b.after", 3'd0, 1'b0, 32'h0, 1'b0);
        step();
        #1 chk_out("t6b.after2", 3'd0, 1'b0, 32'h0, 1'b0);
        chk("t6b.after.epc", bus.int_epc_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
